rf_writeback: RTL and testbench
===============================

# rf_writeback

Writeback unit that drives both write ports of the dual-issue register file. It collects results from the two in-order pipes (slot A older, slot B younger) and from the long-latency path (mul/div, cache-miss loads). Long-latency results are buffered in a small FIFO and retired into whichever write port is idle. Port outputs are registered. The block resolves same-cycle address collisions and requests a pipeline bubble when the long-latency path starves.

## Interface
Parameters:
- DEPTH, 4: long-latency FIFO entries (power of two, ≥2)
- STARVE, 8: consecutive blocked cycles before stall_req

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- a_valid / a_addr / a_data  in  1/5/32  pipe slot A (older) result; always accepted
- b_valid / b_addr / b_data  in  1/5/32  pipe slot B (younger) result; always accepted
- l_valid / l_addr / l_data  in  1/5/32  long-latency result
- l_ready  out  1  FIFO can accept; transfer when l_valid & l_ready
- we1 / waddr1 / wdata1  out  1/5/32  RF write port 1
- we2 / waddr2 / wdata2  out  1/5/32  RF write port 2
- stall_req  out  1  request a pipeline bubble to free a port
- wb_conflict  out  1  sticky error: FIFO head collided with a pipe write
- pending  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- Reset (async) clears: FIFO, starve counter, wb_conflict, all we/waddr/wdata, stall_req; pending=0, l_ready=1 after release. In-flight FIFO entries are discarded.
- Qualification, per cycle:
  - nB = b_valid & b_addr≠0
  - nA = a_valid & a_addr≠0 & ¬(nB & b_addr==a_addr); younger slot wins, A squashed.
  - Address-0 results consume no port and are dropped; FIFO entries with addr 0 are popped without writing.
- Port assignment:
  - nA → port 1; nB → port 2.
  - FIFO head H (if non-empty) → port 2 if ¬nB, else port 1 if ¬nA, else waits.
- Collision: if H targets the same address as a qualified pipe write in the same cycle, the pipe value is written and H is popped without writing. wb_conflict is set and held until reset. The upstream scoreboard forbids long-path/pipe WAW races; this is defensive behaviour only.
- FIFO:
  - l_ready = ¬full, computed from registered count. No push while full, even if a pop occurs that cycle.
  - Push and pop in the same cycle are allowed when not full; occupancy is unchanged.
  - Pointers wrap modulo DEPTH.
- Starve counter:
  - Increments when the FIFO is non-empty and H is not popped; saturates at STARVE.
  - Clears on any pop or when the FIFO is empty.
  - stall_req is registered: asserted in the cycle after the counter reaches STARVE, deasserted in the cycle after the pop.
- Data on an unused port is don't-care, but waddr/wdata hold their last values; we is 0.

## Timing
- Pipe input at cycle t → we/waddr/wdata asserted at t+1, committed in RF at the t+1 edge.
- Long path: handshake at t → entry is head at earliest t+1 → write visible on port at earliest t+2.
- pending and l_ready update one cycle after push/pop.
- Fairness: with both pipes writing every cycle, H retires at the latest STARVE+2 cycles after reaching the head. This assumes the pipeline honours stall_req within one cycle.

## Test plan
- a=(3,0x11), b=(4,0x22) valid at cycle 5 → cycle 6: we1=1,waddr1=3,wdata1=0x11; we2=1,waddr2=4,wdata2=0x22.
- a=(7,0xAA), b=(7,0xBB) → only we2=1,waddr2=7,wdata2=0xBB; we1=0. Separately, a=(0,x) alone → no write.
- l=(9,0x55) handshake at t, pipes idle → t+2: we2=1,waddr2=9,wdata2=0x55; pending returns to 0 at t+2.
- Fill FIFO with 4 entries while both pipes write every cycle → l_ready=0 after 4th push. stall_req rises 1 cycle after the counter reaches 8. Bubble cycle drains the head via port 2. pending decrements.
- FIFO head addr 12 plus a=(12,0x1) same cycle → port 1 writes 0x1, head popped, wb_conflict=1 until rst.
- Assert rst asynchronously with 3 FIFO entries and we1=1 → immediately we1=we2=0, stall_req=0, pending=0. After release, no stale writes appear.

Source files
------------

// File: rtl/rf_writeback.sv
// Writeback unit for the dual-issue register file: merges pipe slots A/B with a
// buffered long-latency path onto two registered write ports.
module rf_writeback #(
  parameter int DEPTH  = 4,
  parameter int STARVE = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     a_valid,
  input  logic [4:0]               a_addr,
  input  logic [31:0]              a_data,
  input  logic                     b_valid,
  input  logic [4:0]               b_addr,
  input  logic [31:0]              b_data,
  input  logic                     l_valid,
  input  logic [4:0]               l_addr,
  input  logic [31:0]              l_data,
  output logic                     l_ready,
  output logic                     we1,
  output logic [4:0]               waddr1,
  output logic [31:0]              wdata1,
  output logic                     we2,
  output logic [4:0]               waddr2,
  output logic [31:0]              wdata2,
  output logic                     stall_req,
  output logic                     wb_conflict,
  output logic [$clog2(DEPTH):0]   pending
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE + 1);
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE);

  logic [4:0]    mem_addr_r [DEPTH];
  logic [31:0]   mem_data_r [DEPTH];
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;
  logic [SW-1:0] starve_r;

  logic          na_s;
  logic          nb_s;
  logic          empty_s;
  logic          full_s;
  logic [4:0]    head_addr_s;
  logic [31:0]   head_data_s;
  logic          coll_s;
  logic          h_to1_s;
  logic          h_to2_s;
  logic          pop_s;
  logic          push_s;
  logic [CW-1:0] count_next_s;
  logic [SW-1:0] starve_next_s;

  // Qualification, head routing, collision detection and FIFO/starve next-state.
  always_comb begin
    nb_s        = b_valid & (b_addr != 5'd0);
    na_s        = a_valid & (a_addr != 5'd0) & ~(nb_s & (b_addr == a_addr));
    empty_s     = (count_r == {CW{1'b0}});
    full_s      = (count_r == FULL_CNT);
    head_addr_s = mem_addr_r[rd_ptr_r];
    head_data_s = mem_data_r[rd_ptr_r];
    // A colliding head is dropped: the pipe value is the architecturally newer one.
    coll_s      = ~empty_s & ((na_s & (head_addr_s == a_addr)) |
                              (nb_s & (head_addr_s == b_addr)));
    h_to2_s     = ~empty_s & (head_addr_s != 5'd0) & ~coll_s & ~nb_s;
    h_to1_s     = ~empty_s & (head_addr_s != 5'd0) & ~coll_s & nb_s & ~na_s;
    pop_s       = ~empty_s & ((head_addr_s == 5'd0) | coll_s | h_to1_s | h_to2_s);
    push_s      = l_valid & ~full_s;

    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CW'(1);
      2'b01:   count_next_s = count_r - CW'(1);
      default: count_next_s = count_r;
    endcase

    if (empty_s | pop_s) begin
      starve_next_s = {SW{1'b0}};
    end else if (starve_r != STARVE_MAX) begin
      starve_next_s = starve_r + SW'(1);
    end else begin
      starve_next_s = starve_r;
    end
  end

  // FIFO payload storage; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_addr_r[wr_ptr_r] <= l_addr;
      mem_data_r[wr_ptr_r] <= l_data;
    end
  end

  // Control state and registered write-port outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_r    <= {AW{1'b0}};
      wr_ptr_r    <= {AW{1'b0}};
      count_r     <= {CW{1'b0}};
      starve_r    <= {SW{1'b0}};
      stall_req   <= 1'b0;
      wb_conflict <= 1'b0;
      we1         <= 1'b0;
      waddr1      <= 5'd0;
      wdata1      <= 32'd0;
      we2         <= 1'b0;
      waddr2      <= 5'd0;
      wdata2      <= 32'd0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      count_r     <= count_next_s;
      starve_r    <= starve_next_s;
      stall_req   <= (starve_next_s == STARVE_MAX);
      wb_conflict <= wb_conflict | coll_s;

      we1 <= na_s | h_to1_s;
      if (na_s) begin
        waddr1 <= a_addr;
        wdata1 <= a_data;
      end else if (h_to1_s) begin
        waddr1 <= head_addr_s;
        wdata1 <= head_data_s;
      end

      we2 <= nb_s | h_to2_s;
      if (nb_s) begin
        waddr2 <= b_addr;
        wdata2 <= b_data;
      end else if (h_to2_s) begin
        waddr2 <= head_addr_s;
        wdata2 <= head_data_s;
      end
    end
  end

  assign l_ready = (count_r != FULL_CNT);
  assign pending = count_r;

endmodule

// File: tb/tb_rf_writeback.sv
// Randomised scoreboard bench for rf_writeback against a queue-based reference model.
module tb_rf_writeback;
  localparam int DEPTH  = 4;
  localparam int STARVE = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_valid, b_valid, l_valid;
  logic [4:0]  a_addr, b_addr, l_addr;
  logic [31:0] a_data, b_data, l_data;
  logic        l_ready, we1, we2, stall_req, wb_conflict;
  logic [4:0]  waddr1, waddr2;
  logic [31:0] wdata1, wdata2;
  logic [2:0]  pending;

  always #5 clk = ~clk;

  rf_writeback #(.DEPTH(DEPTH), .STARVE(STARVE)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data),
    .l_valid(l_valid), .l_addr(l_addr), .l_data(l_data), .l_ready(l_ready),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .we2(we2), .waddr2(waddr2), .wdata2(wdata2),
    .stall_req(stall_req), .wb_conflict(wb_conflict), .pending(pending)
  );

  typedef struct { logic [4:0] addr; logic [31:0] data; } ent_t;
  typedef struct {
    logic we1; logic [4:0] a1; logic [31:0] d1;
    logic we2; logic [4:0] a2; logic [31:0] d2;
    logic stall; logic conf; logic [2:0] pend; logic lrdy;
  } exp_t;

  ent_t  mq[$];
  exp_t  exp_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    streak;
  logic  m_conf;
  logic [4:0]  m_a1, m_a2;
  logic [31:0] m_d1, m_d2;
  bit    started = 0;

  function automatic bit chk(string name, logic [31:0] act, logic [31:0] exp);
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic check_now(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (chk(name, act, exp)) miscompares++;
  endtask

  task automatic model_reset();
    mq.delete();
    streak = 0;
    m_conf = 1'b0;
    m_a1 = 5'd0; m_a2 = 5'd0; m_d1 = 32'd0; m_d2 = 32'd0;
  endtask

  // One clock of the architectural rules, applied to the inputs just sampled.
  task automatic model_step();
    exp_t e;
    ent_t h;
    bit   na, nb, popped;
    int   sz;
    sz = mq.size();
    nb = b_valid && (b_addr != 5'd0);
    na = a_valid && (a_addr != 5'd0) && !(nb && b_addr == a_addr);
    e.we1 = na;
    e.we2 = nb;
    if (na) begin m_a1 = a_addr; m_d1 = a_data; end
    if (nb) begin m_a2 = b_addr; m_d2 = b_data; end
    popped = 1'b0;
    if (sz > 0) begin
      h = mq[0];
      popped = 1'b1;
      if (h.addr == 5'd0) begin
      end else if ((na && h.addr == a_addr) || (nb && h.addr == b_addr)) begin
        m_conf = 1'b1;
      end else if (!nb) begin
        e.we2 = 1'b1; m_a2 = h.addr; m_d2 = h.data;
      end else if (!na) begin
        e.we1 = 1'b1; m_a1 = h.addr; m_d1 = h.data;
      end else begin
        popped = 1'b0;
      end
    end
    if (popped) h = mq.pop_front();
    if (l_valid && sz < DEPTH) mq.push_back('{l_addr, l_data});
    if (sz == 0 || popped) streak = 0;
    else if (streak < STARVE) streak++;
    e.a1 = m_a1; e.d1 = m_d1; e.a2 = m_a2; e.d2 = m_d2;
    e.stall = (streak == STARVE);
    e.conf  = m_conf;
    e.pend  = 3'(mq.size());
    e.lrdy  = (mq.size() < DEPTH);
    exp_q.push_back(e);
    started = 1;
  endtask

  task automatic cycle(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld);
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    l_valid = lv; l_addr = la; l_data = ld;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  // Monitor: every cycle the registered outputs are compared with the oldest expectation.
  initial begin
    exp_t e;
    bit   bad;
    forever begin
      @(negedge clk);
      if (!rst && started) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL queue_underflow: got no expectation, required one at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          bad = 1'b0;
          bad |= chk("we1", 32'(we1), 32'(e.we1));
          bad |= chk("waddr1", 32'(waddr1), 32'(e.a1));
          bad |= chk("wdata1", wdata1, e.d1);
          bad |= chk("we2", 32'(we2), 32'(e.we2));
          bad |= chk("waddr2", 32'(waddr2), 32'(e.a2));
          bad |= chk("wdata2", wdata2, e.d2);
          bad |= chk("stall_req", 32'(stall_req), 32'(e.stall));
          bad |= chk("wb_conflict", 32'(wb_conflict), 32'(e.conf));
          bad |= chk("pending", 32'(pending), 32'(e.pend));
          bad |= chk("l_ready", 32'(l_ready), 32'(e.lrdy));
          if (bad) miscompares++;
        end
      end
    end
  end

  initial begin
    a_valid = 1'b0; a_addr = 5'd0; a_data = 32'd0;
    b_valid = 1'b0; b_addr = 5'd0; b_data = 32'd0;
    l_valid = 1'b0; l_addr = 5'd0; l_data = 32'd0;
    model_reset();
    #12;
    check_now("rst_we1", 32'(we1), 32'd0);
    check_now("rst_we2", 32'(we2), 32'd0);
    check_now("rst_stall", 32'(stall_req), 32'd0);
    check_now("rst_conflict", 32'(wb_conflict), 32'd0);
    check_now("rst_pending", 32'(pending), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    idle(4);
    cycle(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 1'b0, 5'd0, 32'd0);
    cycle(1'b1, 5'd7, 32'hAA, 1'b1, 5'd7, 32'hBB, 1'b0, 5'd0, 32'd0);
    cycle(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h55);
    idle(3);

    // Both pipes busy: FIFO fills, starves, then a bubble on slot B drains it.
    for (int i = 0; i < 14; i++)
      cycle(1'b1, 5'd1, $urandom(), 1'b1, 5'd2, $urandom(), (i < 6), 5'(20 + i), $urandom());
    for (int i = 0; i < 6; i++)
      cycle(1'b1, 5'd1, $urandom(), 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    idle(2);

    // Head at address 12 collides with slot A.
    cycle(1'b1, 5'd1, 32'h5, 1'b1, 5'd2, 32'h6, 1'b1, 5'd12, 32'h77);
    cycle(1'b1, 5'd12, 32'h1, 1'b1, 5'd2, 32'h6, 1'b0, 5'd0, 32'd0);
    idle(3);

    // Asynchronous reset with three entries queued and port 1 active.
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 5'd5, $urandom(), 1'b1, 5'd6, $urandom(), 1'b1, 5'(24 + i), $urandom());
    cycle(1'b1, 5'd5, 32'hCAFE, 1'b1, 5'd6, 32'hBEEF, 1'b0, 5'd0, 32'd0);
    #1 rst = 1'b1;
    exp_q.delete();
    started = 0;
    #1;
    check_now("arst_we1", 32'(we1), 32'd0);
    check_now("arst_we2", 32'(we2), 32'd0);
    check_now("arst_stall", 32'(stall_req), 32'd0);
    check_now("arst_pending", 32'(pending), 32'd0);
    check_now("arst_conflict", 32'(wb_conflict), 32'd0);
    model_reset();
    a_valid = 1'b0; b_valid = 1'b0; l_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(6);

    for (int i = 0; i < 1500; i++) begin
      logic [4:0] aa, ba, la;
      aa = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      ba = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      la = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      cycle(($urandom_range(0, 3) != 0), aa, $urandom(),
            ($urandom_range(0, 3) != 0), ba, $urandom(),
            ($urandom_range(0, 1) == 0), la, $urandom());
    end
    idle(8);

    @(negedge clk);
    #1;
    check_now("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
